clk_ce_gen: RTL and testbench

- Parametrised successor to the single-output fixed PLL wrapper: an N-channel fractional clock-enable generator running on the board reference clock.
- Each channel owns a phase accumulator (NCO). Its carry-out becomes a one-cycle clock-enable pulse at refclk × inc / 2^ACC_W.
- Increments can be reprogrammed at run time via a valid/ready config port.
- A PLL-style `locked` output flags when all channels are settled and producing enables. Downstream core logic uses these enables instead of extra PLL outputs.

---
 rtl/clk_ce_gen_pkg.sv | 28 ++
 rtl/clk_ce_nco.sv | 71 +++++++
 rtl/clk_ce_gen.sv | 119 +++++++++++
 tb/tb_clk_ce_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ce_gen_pkg.sv
// Shared types and helpers for the clk_ce_gen clock-enable generator.
// Optional feature macro: CLK_CE_GEN_TOGGLE_EN (adds per-channel toggle outputs).
package clk_ce_gen_pkg;

  // Board reference clock frequency.
  localparam longint unsigned REF_CLK_HZ = 64'd50_000_000;

  // Lock sequencing states.
  typedef enum logic [1:0] {
    StHold   = 2'd0,
    StSettle = 2'd1,
    StLocked = 2'd2
  } state_e;

  // NCO increment that yields out_hz enables from ref_hz with an acc_w-bit accumulator.
  // The result is truncated (rounded down) to an integer increment.
  function automatic longint unsigned calc_inc(input longint unsigned ref_hz,
                                               input longint unsigned out_hz,
                                               input int unsigned     acc_w);
    return (out_hz << acc_w) / ref_hz;
  endfunction

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_ce_nco.sv
// One phase-accumulator channel: registered carry-out enable, optional toggle output.
// Optional feature macro: CLK_CE_GEN_TOGGLE_EN (adds tog_o).
module clk_ce_nco #(
  parameter int unsigned AccW = 24
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            clear_i,
  input  logic [AccW-1:0] inc_i,
  output logic            ce_o
`ifdef CLK_CE_GEN_TOGGLE_EN
  ,
  output logic            tog_o
`endif
);

  logic [AccW-1:0] acc_q, acc_d;
  logic            ce_q, ce_d;
  logic [AccW:0]   sum;

  // Add one bit wider so the top bit is the wrap carry.
  assign sum = {1'b0, acc_q} + {1'b0, inc_i};

  // Next accumulator and enable: held at zero unless running and not being cleared.
  always_comb begin
    acc_d = '0;
    ce_d  = 1'b0;
    if (run_i && !clear_i) begin
      acc_d = sum[AccW-1:0];
      ce_d  = sum[AccW];
    end
  end

  // Accumulator and registered enable pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

`ifdef CLK_CE_GEN_TOGGLE_EN
  logic tog_q, tog_d;

  // Flip on the same edge the enable pulse is registered, so each pulse is one toggle.
  always_comb begin
    tog_d = 1'b0;
    if (run_i && !clear_i) begin
      tog_d = tog_q ^ ce_d;
    end
  end

  // Square-wave toggle register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign tog_o = tog_q;
`endif

endmodule

// File: rtl/clk_ce_gen.sv
// N-channel fractional clock-enable generator on the reference clock, with run-time
// reprogrammable increments and a PLL-style lock indication.
// Optional feature macro: CLK_CE_GEN_TOGGLE_EN (adds clk_out square-wave outputs).
module clk_ce_gen
  import clk_ce_gen_pkg::*;
#(
  parameter int unsigned       CHANNELS    = 2,
  parameter int unsigned       ACC_W       = 24,
  parameter logic [ACC_W-1:0]  INC_DEFAULT = 24'h48E8A7,
  parameter int unsigned       LOCK_CYCLES = 16
) (
  input  logic                            refclk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [chan_width(CHANNELS)-1:0] cfg_chan,
  input  logic [ACC_W-1:0]                cfg_inc,
  output logic [CHANNELS-1:0]             ce_out,
  output logic                            locked
`ifdef CLK_CE_GEN_TOGGLE_EN
  ,
  output logic [CHANNELS-1:0]             clk_out
`endif
);

  localparam int unsigned CntW = $clog2(LOCK_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            locked_q;
  logic            cfg_ready_q;

  logic        cfg_fire;
  logic        cfg_hit;
  logic [31:0] cfg_chan_ext;
  logic        run;

  // A transfer always completes; only an in-range channel causes a reload and relock.
  assign cfg_chan_ext = 32'(cfg_chan);
  assign cfg_fire     = cfg_valid && cfg_ready_q;
  assign cfg_hit      = cfg_fire && (cfg_chan_ext < CHANNELS);
  assign run          = (state_q == StLocked);

  // Lock sequencer with registered locked/cfg_ready outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      // Ready from the first SETTLE cycle onward; only reset takes it away.
      cfg_ready_q <= 1'b1;
      unique case (state_q)
        StHold: begin
          state_q <= StSettle;
          cnt_q   <= '0;
        end
        StSettle: begin
          if (cfg_hit) begin
            // A new config restarts settling even on the final count.
            cnt_q <= '0;
          end else if (cnt_q == CntLast) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StLocked: begin
          if (cfg_hit) begin
            state_q  <= StSettle;
            locked_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        default: begin
          state_q  <= StHold;
          locked_q <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign locked    = locked_q;
  assign cfg_ready = cfg_ready_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [ACC_W-1:0] inc_q;

    // Per-channel increment, reloaded by an accepted config aimed at this channel.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        inc_q <= INC_DEFAULT;
      end else if (cfg_hit && (cfg_chan_ext == 32'(g))) begin
        inc_q <= cfg_inc;
      end
    end

    clk_ce_nco #(
      .AccW (ACC_W)
    ) u_nco (
      .clk_i   (refclk),
      .rst_i   (rst),
      .run_i   (run),
      .clear_i (cfg_hit),
      .inc_i   (inc_q),
      .ce_o    (ce_out[g])
`ifdef CLK_CE_GEN_TOGGLE_EN
      ,
      .tog_o   (clk_out[g])
`endif
    );
  end

endmodule

// File: tb/tb_clk_ce_gen.sv
// Directed self-checking bench for clk_ce_gen (3 channels, 16-bit accumulators).
// Optional feature macro: CLK_CE_GEN_TOGGLE_EN (also checks clk_out).
module tb_clk_ce_gen;
  import clk_ce_gen_pkg::*;

  localparam int unsigned CH = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned LC = 16;
  localparam logic [W-1:0] DEF = W'(calc_inc(REF_CLK_HZ, 64'd14_236_111, W));

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_chan;
  logic [W-1:0]  cfg_inc;
  logic [CH-1:0] ce_out;
  logic          locked;
`ifdef CLK_CE_GEN_TOGGLE_EN
  logic [CH-1:0] clk_out;
`endif

  clk_ce_gen #(
    .CHANNELS    (CH),
    .ACC_W       (W),
    .INC_DEFAULT (DEF),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_inc   (cfg_inc),
    .ce_out    (ce_out),
    .locked    (locked)
`ifdef CLK_CE_GEN_TOGGLE_EN
    ,
    .clk_out   (clk_out)
`endif
  );

  always #10 refclk = ~refclk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic expect_val(input string tag, input logic [63:0] e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t it;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0d expected <entry>", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", it.tag, obs, it.exp);
    end
  endtask

  // Step one cycle: rising edge then sample on the falling edge.
  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Count cycles until locked (bounded), plus cycles seen with any enable high.
  task automatic wait_lock(output int n, output int pulses);
    n = 0;
    pulses = 0;
    do begin
      step();
      n++;
      if (ce_out != '0) pulses++;
    end while (!locked && n < 200);
  endtask

  // Called at a falling edge; the transfer lands on the next rising edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [W-1:0] inc);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_inc   = inc;
    step();
    cfg_valid = 1'b0;
  endtask

  // Bounded search for a cycle where ch0 pulses.
  task automatic find_pulse0();
    int k;
    k = 0;
    while (!ce_out[0] && k < 10) begin
      step();
      k++;
    end
  endtask

  initial begin
    int n, pre;
    int c0, c1, c2, tog;
    logic lk, prev;
    logic [19:0] obs20, exp20;
    logic [11:0] obs12, exp12;

    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_inc   = '0;
    repeat (3) @(negedge refclk);

    expect_val("reset_ce_out", 0);    check(64'(ce_out));
    expect_val("reset_locked", 0);    check(64'(locked));
    expect_val("reset_cfg_ready", 0); check(64'(cfg_ready));

    rst = 1'b0;
    expect_val("hold_cfg_ready", 0); check(64'(cfg_ready));
    expect_val("lock_latency", 1 + LC);
    expect_val("pulses_before_lock", 0);
    wait_lock(n, pre);
    check(64'(n));
    check(64'(pre));

    // Reprogram ch0 to a quarter-rate increment.
    expect_val("locked_drop_after_write", 0);
    cfg_write(2'd0, 16'h4000);
    check(64'(locked));
    expect_val("relock_latency", LC);
    wait_lock(n, pre);
    check(64'(n));
    for (int j = 1; j <= 20; j++) exp20[j-1] = (j % 4 == 0);
    expect_val("ch0_quarter_pattern", 64'(exp20));
    for (int j = 1; j <= 20; j++) begin
      step();
      obs20[j-1] = ce_out[0];
    end
    check(64'(obs20));

    // Disable ch1; ch0 and ch2 keep running.
    cfg_write(2'd1, '0);
    wait_lock(n, pre);
    expect_val("ch1_disabled_pulses", 0);
    expect_val("ch0_pulses_1000", (64'd1000 * 64'h4000) >> W);
    expect_val("ch2_pulses_1000", (64'd1000 * 64'(DEF)) >> W);
    c0 = 0; c1 = 0; c2 = 0;
    for (int j = 0; j < 1000; j++) begin
      step();
      c0 += int'(ce_out[0]);
      c1 += int'(ce_out[1]);
      c2 += int'(ce_out[2]);
    end
    check(64'(c1));
    check(64'(c0));
    check(64'(c2));

    // Out-of-range channel: transfer completes, nothing changes.
    find_pulse0();
    expect_val("found_ch0_pulse", 1);  check(64'(ce_out[0]));
    expect_val("bad_chan_ready", 1);   check(64'(cfg_ready));
    for (int j = 1; j <= 12; j++) exp12[j-1] = (j % 4 == 0);
    expect_val("bad_chan_pattern", 64'(exp12));
    expect_val("bad_chan_locked", 1);
    cfg_write(2'd3, 16'h1234);
    obs12[0] = ce_out[0];
    lk = locked;
    for (int j = 2; j <= 12; j++) begin
      step();
      obs12[j-1] = ce_out[0];
      lk &= locked;
    end
    check(64'(obs12));
    check(64'(lk));

    // Accept coinciding with the final settle count restarts settling.
    cfg_write(2'd0, 16'h4000);
    repeat (LC - 1) @(negedge refclk);
    expect_val("accept_on_last_count_locked", 0);
    cfg_write(2'd0, 16'h4000);
    check(64'(locked));
    expect_val("relock_after_collision", LC);
    wait_lock(n, pre);
    check(64'(n));

    // Reset mid-lock, caught while an enable is high.
    find_pulse0();
    expect_val("pre_reset_ch0_pulse", 1); check(64'(ce_out[0]));
    rst = 1'b1;
    #1;
    expect_val("midreset_ce_out", 0);    check(64'(ce_out));
    expect_val("midreset_locked", 0);    check(64'(locked));
    expect_val("midreset_cfg_ready", 0); check(64'(cfg_ready));
`ifdef CLK_CE_GEN_TOGGLE_EN
    expect_val("midreset_clk_out", 0);   check(64'(clk_out));
`endif
    @(negedge refclk);
    rst = 1'b0;
    expect_val("relock_after_reset", 1 + LC);
    wait_lock(n, pre);
    check(64'(n));
    expect_val("ch0_default_rate_25000", (64'd25000 * 64'(DEF)) >> W);
    expect_val("ch1_default_rate_25000", (64'd25000 * 64'(DEF)) >> W);
`ifdef CLK_CE_GEN_TOGGLE_EN
    expect_val("clk_out0_toggles", (64'd25000 * 64'(DEF)) >> W);
    prev = clk_out[0];
`else
    prev = 1'b0;
`endif
    c0 = 0; c1 = 0; tog = 0;
    for (int j = 0; j < 25000; j++) begin
      step();
      c0 += int'(ce_out[0]);
      c1 += int'(ce_out[1]);
`ifdef CLK_CE_GEN_TOGGLE_EN
      if (clk_out[0] != prev) tog++;
      prev = clk_out[0];
`endif
    end
    check(64'(c0));
    check(64'(c1));
`ifdef CLK_CE_GEN_TOGGLE_EN
    check(64'(tog));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
